// File: rtl/control_coordinator.sv
// control_coordinator -- dispatch stage behind the look-ahead buffer.
//
// A single hold register accepts one instruction at a time. The opcode is
// decoded and the instruction is issued, in order, to the weight-load,
// matrix-multiply or activation unit. Issue waits until no data hazard is
// left between the units. The buffer is back-pressured through instr_busy.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   enable                       0 freezes the block: no capture, no dispatch
//   instr_in / instr_en          instruction from the buffer and its valid bit
//   instr_busy                   combinational: cannot accept this cycle
//   <unit>_instr / <unit>_en     registered instruction and one-cycle issue pulse
//   <unit>_busy                  busy status from each unit
//   synchronize                  one-cycle pulse when a SYNC completes
//   illegal_opcode               sticky flag set by an undefined opcode

package tpu_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] calc_length;
        logic [15:0] acc_addr;
        logic [23:0] buffer_addr;
    } instr_type;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LW   = 8'h08;
    localparam logic [7:0] OP_MM   = 8'h20;
    localparam logic [7:0] OP_ACT  = 8'h80;
    localparam logic [7:0] OP_SYNC = 8'hFF;

    localparam instr_type INIT_INSTR = '0;
endpackage

module control_coordinator
    import tpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    input  instr_type instr_in,
    input  logic      instr_en,
    output logic      instr_busy,
    output instr_type weight_instr,
    output logic      weight_en,
    input  logic      weight_busy,
    output instr_type matmul_instr,
    output logic      matmul_en,
    input  logic      matmul_busy,
    output instr_type activation_instr,
    output logic      activation_en,
    input  logic      activation_busy,
    output logic      synchronize,
    output logic      illegal_opcode
);

    logic      hold_valid_q, hold_valid_d;
    instr_type hold_q, hold_d;
    logic      weight_en_q, weight_en_d;
    logic      matmul_en_q, matmul_en_d;
    logic      act_en_q, act_en_d;
    logic      sync_q, sync_d;
    logic      illegal_q, illegal_d;
    instr_type weight_instr_q, weight_instr_d;
    instr_type matmul_instr_q, matmul_instr_d;
    instr_type act_instr_q, act_instr_d;

    logic occ_w, occ_m, occ_a;
    logic ready, fire, capture;
    logic is_lw, is_mm, is_act, is_sync, is_ill;

    // A unit raises busy only the cycle after its issue pulse. The pulse
    // itself therefore marks the unit as occupied during that gap.
    assign occ_w = weight_busy     | weight_en_q;
    assign occ_m = matmul_busy     | matmul_en_q;
    assign occ_a = activation_busy | act_en_q;

    always_comb begin
        is_lw   = 1'b0;
        is_mm   = 1'b0;
        is_act  = 1'b0;
        is_sync = 1'b0;
        is_ill  = 1'b0;
        ready   = 1'b1;
        unique case (hold_q.opcode)
            OP_NOP:  ;
            OP_LW:   begin is_lw   = 1'b1; ready = ~occ_w;                   end
            OP_MM:   begin is_mm   = 1'b1; ready = ~occ_m & ~occ_w;          end
            OP_ACT:  begin is_act  = 1'b1; ready = ~occ_a & ~occ_m;          end
            OP_SYNC: begin is_sync = 1'b1; ready = ~occ_w & ~occ_m & ~occ_a; end
            default: is_ill = 1'b1;
        endcase
    end

    assign fire       = enable & hold_valid_q & ready;
    // The slot may be refilled in the same cycle that it fires.
    assign instr_busy = ~enable | (hold_valid_q & ~fire);
    assign capture    = instr_en & ~instr_busy;

    always_comb begin
        hold_valid_d   = hold_valid_q;
        hold_d         = hold_q;
        weight_instr_d = weight_instr_q;
        matmul_instr_d = matmul_instr_q;
        act_instr_d    = act_instr_q;

        if (fire) hold_valid_d = 1'b0;
        if (capture) begin
            hold_valid_d = 1'b1;
            hold_d       = instr_in;
        end

        weight_en_d = fire & is_lw;
        matmul_en_d = fire & is_mm;
        act_en_d    = fire & is_act;
        sync_d      = fire & is_sync;
        illegal_d   = illegal_q | (fire & is_ill);

        if (weight_en_d) weight_instr_d = hold_q;
        if (matmul_en_d) matmul_instr_d = hold_q;
        if (act_en_d)    act_instr_d    = hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q   <= 1'b0;
            hold_q         <= INIT_INSTR;
            weight_en_q    <= 1'b0;
            matmul_en_q    <= 1'b0;
            act_en_q       <= 1'b0;
            sync_q         <= 1'b0;
            illegal_q      <= 1'b0;
            weight_instr_q <= INIT_INSTR;
            matmul_instr_q <= INIT_INSTR;
            act_instr_q    <= INIT_INSTR;
        end else begin
            hold_valid_q   <= hold_valid_d;
            hold_q         <= hold_d;
            weight_en_q    <= weight_en_d;
            matmul_en_q    <= matmul_en_d;
            act_en_q       <= act_en_d;
            sync_q         <= sync_d;
            illegal_q      <= illegal_d;
            weight_instr_q <= weight_instr_d;
            matmul_instr_q <= matmul_instr_d;
            act_instr_q    <= act_instr_d;
        end
    end

    assign weight_en        = weight_en_q;
    assign matmul_en        = matmul_en_q;
    assign activation_en    = act_en_q;
    assign synchronize      = sync_q;
    assign illegal_opcode   = illegal_q;
    assign weight_instr     = weight_instr_q;
    assign matmul_instr     = matmul_instr_q;
    assign activation_instr = act_instr_q;

endmodule

// File: tb/tb_control_coordinator.sv
// Randomized plus scripted bench for control_coordinator. The reference model
// tracks the accepted instruction, works out hazards from a table of the units
// that each opcode depends on, and predicts every output cycle by cycle.
module tb_control_coordinator;
    import tpu_pkg::*;

    logic      clk = 1'b0;
    logic      rst, enable, instr_en, instr_busy;
    instr_type instr_in, weight_instr, matmul_instr, activation_instr;
    logic      weight_en, weight_busy, matmul_en, matmul_busy;
    logic      activation_en, activation_busy, synchronize, illegal_opcode;

    control_coordinator dut (
        .clk(clk), .rst(rst), .enable(enable),
        .instr_in(instr_in), .instr_en(instr_en), .instr_busy(instr_busy),
        .weight_instr(weight_instr), .weight_en(weight_en), .weight_busy(weight_busy),
        .matmul_instr(matmul_instr), .matmul_en(matmul_en), .matmul_busy(matmul_busy),
        .activation_instr(activation_instr), .activation_en(activation_en),
        .activation_busy(activation_busy),
        .synchronize(synchronize), .illegal_opcode(illegal_opcode)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: unit index 0 weight, 1 matmul, 2 activation.
    bit        m_hv;
    instr_type m_hold;
    bit [2:0]  m_en;
    bit        m_sync, m_ill;
    instr_type m_instr [3];

    // Units an opcode must find idle before it may issue.
    function automatic bit [2:0] needs(input logic [7:0] op);
        case (op)
            OP_LW:   return 3'b001;
            OP_MM:   return 3'b011;
            OP_ACT:  return 3'b110;
            OP_SYNC: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Unit that receives the opcode: 0..2, 3 for SYNC, -1 for none.
    function automatic int target(input logic [7:0] op);
        case (op)
            OP_LW:   return 0;
            OP_MM:   return 1;
            OP_ACT:  return 2;
            OP_SYNC: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(input logic [7:0] op);
        return op == OP_NOP || op == OP_LW || op == OP_MM || op == OP_ACT || op == OP_SYNC;
    endfunction

    function automatic instr_type mk(input logic [7:0] op, input logic [31:0] len);
        instr_type t;
        t.opcode      = op;
        t.calc_length = len;
        t.acc_addr    = 16'($urandom);
        t.buffer_addr = 24'($urandom);
        return t;
    endfunction

    task automatic model_reset();
        m_hv = 0; m_hold = '0; m_en = '0; m_sync = 0; m_ill = 0;
        for (int u = 0; u < 3; u++) m_instr[u] = INIT_INSTR;
    endtask

    task automatic check_outs(input string p);
        chk({p, "weight_en"},     80'(weight_en),      80'(m_en[0]));
        chk({p, "matmul_en"},     80'(matmul_en),      80'(m_en[1]));
        chk({p, "activation_en"}, 80'(activation_en),  80'(m_en[2]));
        chk({p, "synchronize"},   80'(synchronize),    80'(m_sync));
        chk({p, "illegal"},       80'(illegal_opcode), 80'(m_ill));
        chk({p, "weight_instr"},  weight_instr,        m_instr[0]);
        chk({p, "matmul_instr"},  matmul_instr,        m_instr[1]);
        chk({p, "act_instr"},     activation_instr,    m_instr[2]);
    endtask

    // One clock cycle: entered just after a rising edge and left just after the next one.
    task automatic step(input bit en, input bit ie, input instr_type ins,
                        input bit wb, input bit mb, input bit ab, output bit cap);
        bit [2:0] busy_units;
        bit [2:0] occ;
        bit       fire, exp_busy;
        int       t;
        enable = en; instr_en = ie; instr_in = ins;
        weight_busy = wb; matmul_busy = mb; activation_busy = ab;
        @(negedge clk);
        busy_units = {ab, mb, wb};
        occ        = busy_units | m_en;
        fire       = en && m_hv && ((needs(m_hold.opcode) & occ) == 3'b000);
        exp_busy   = !en || (m_hv && !fire);
        chk("instr_busy", 80'(instr_busy), 80'(exp_busy));
        cap    = ie && !exp_busy;
        m_en   = '0;
        m_sync = 0;
        if (fire) begin
            t = target(m_hold.opcode);
            if (t >= 0 && t < 3) begin
                m_en[t]    = 1'b1;
                m_instr[t] = m_hold;
            end
            if (t == 3) m_sync = 1;
            if (!legal(m_hold.opcode)) m_ill = 1;
            m_hv = 0;
        end
        if (cap) begin
            m_hv   = 1;
            m_hold = ins;
        end
        @(posedge clk); #1;
        check_outs("");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("rst_");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scripted scenarios: instructions are presented in order until accepted,
    // with per-cycle busy {a,m,w} and enable schedules.
    instr_type src [$];
    bit [2:0]  bs [0:15];
    bit        es [0:15];

    task automatic clear_sched();
        for (int i = 0; i < 16; i++) begin bs[i] = '0; es[i] = 1'b1; end
    endtask

    task automatic run(input int n);
        bit cap;
        for (int i = 0; i < n; i++) begin
            step(es[i], src.size() > 0, (src.size() > 0) ? src[0] : INIT_INSTR,
                 bs[i][0], bs[i][1], bs[i][2], cap);
            if (cap) void'(src.pop_front());
        end
    endtask

    initial begin
        bit        cap;
        instr_type cur;
        bit        have;
        logic [7:0] op;
        rst = 1'b1; enable = 1'b1; instr_en = 1'b0; instr_in = '0;
        weight_busy = 0; matmul_busy = 0; activation_busy = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_outs("rst_");
        rst = 1'b0;

        // Idle after reset: instr_busy must be low with enable high.
        clear_sched(); run(2);

        // Single LOAD_WEIGHT with idle units.
        clear_sched();
        src.push_back(mk(OP_LW, 32'd14));
        run(4);
        chk("t2_len", 80'(weight_instr.calc_length), 80'(32'd14));

        // LOAD_WEIGHT then MATMUL; weight busy for 5 cycles after its pulse.
        clear_sched();
        src.push_back(mk(OP_LW, 32'd3));
        src.push_back(mk(OP_MM, 32'd7));
        for (int i = 3; i < 8; i++) bs[i][0] = 1'b1;
        run(12);

        // MATMUL, LOAD_WEIGHT preload, ACTIVATE waiting on matmul.
        clear_sched();
        src.push_back(mk(OP_MM, 32'd9));
        src.push_back(mk(OP_LW, 32'd5));
        src.push_back(mk(OP_ACT, 32'd2));
        for (int i = 3; i < 7; i++) bs[i][1] = 1'b1;
        run(12);

        // SYNC while activation is busy, then a NOP.
        clear_sched();
        src.push_back(mk(OP_SYNC, 32'd0));
        src.push_back(mk(OP_NOP, 32'd0));
        for (int i = 0; i < 3; i++) bs[i][2] = 1'b1;
        run(8);

        // Illegal opcode, then a 3-cycle freeze while more instructions wait.
        clear_sched();
        src.push_back(mk(8'h42, 32'd1));
        src.push_back(mk(OP_LW, 32'd11));
        src.push_back(mk(OP_ACT, 32'd12));
        for (int i = 2; i < 5; i++) es[i] = 1'b0;
        run(10);
        chk("t6_sticky", 80'(illegal_opcode), 80'(1'b1));

        // Reset in the middle of activity.
        clear_sched();
        src.push_back(mk(OP_LW, 32'd1));
        src.push_back(mk(OP_MM, 32'd2));
        bs[2] = 3'b001;
        run(3);
        do_reset();
        src.delete();

        // Random traffic.
        have = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!have) begin
                case ($urandom_range(0, 6))
                    0: op = OP_NOP;
                    1, 2: op = OP_LW;
                    3: op = OP_MM;
                    4: op = OP_ACT;
                    5: op = OP_SYNC;
                    default: op = 8'($urandom);
                endcase
                cur  = mk(op, $urandom);
                have = 1;
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, cur,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, cap);
            if (cap) have = 0;
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
